// File: rtl/execute_adder_pipe_pkg.sv
// Shared command codes and flag bundle for the pipelined execute-stage adder.
// ADC/SBC occupy previously unused 5-bit codes after the original set.
package execute_adder_pipe_pkg;

  typedef enum logic [4:0] {
    EXE_ADDER_ADD    = 5'h00,
    EXE_ADDER_SUB    = 5'h01,
    EXE_ADDER_NEG    = 5'h02,
    EXE_ADDER_COUT   = 5'h03,
    EXE_ADDER_SEXT8  = 5'h04,
    EXE_ADDER_SEXT16 = 5'h05,
    EXE_ADDER_MAX    = 5'h06,
    EXE_ADDER_MIN    = 5'h07,
    EXE_ADDER_UMAX   = 5'h08,
    EXE_ADDER_UMIN   = 5'h09,
    EXE_ADDER_ADC    = 5'h0A,
    EXE_ADDER_SBC    = 5'h0B
  } adderCmdE;

  typedef struct packed {
    logic sf;
    logic of;
    logic cf;
    logic pf;
    logic zf;
  } adderFlagsT;

  // Commands that run A + ~B + 1 through the chain (compares included).
  function automatic logic isSubtractCmd(input logic [4:0] cmd);
    return (cmd == EXE_ADDER_SUB)  || (cmd == EXE_ADDER_MAX)  ||
           (cmd == EXE_ADDER_MIN)  || (cmd == EXE_ADDER_UMAX) ||
           (cmd == EXE_ADDER_UMIN);
  endfunction

endpackage

// File: rtl/execute_adder_pipe_seg.sv
// One carry segment of the adder pipeline: adds its slice with the incoming carry
// and registers the whole in-flight op, holding on stall and dropping valid on flush.
module execute_adder_pipe_seg #(
  parameter int P_N   = 32,
  parameter int P_SEG = 16,
  parameter int P_IDX = 0
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           stall_i,
  input  logic           flush_i,
  input  logic           valid_i,
  input  logic [4:0]     cmd_i,
  input  logic [P_N-1:0] a_i,
  input  logic [P_N-1:0] b_i,
  input  logic [P_N-1:0] sum_i,
  input  logic           carry_i,
  output logic           valid_o,
  output logic [4:0]     cmd_o,
  output logic [P_N-1:0] a_o,
  output logic [P_N-1:0] b_o,
  output logic [P_N-1:0] sum_o,
  output logic           carry_o
);

  localparam int LO = P_IDX * P_SEG;

  logic [P_SEG:0]   segSum;
  logic [P_N-1:0]   sum_d;
  logic             valid_q;
  logic [4:0]       cmd_q;
  logic [P_N-1:0]   a_q;
  logic [P_N-1:0]   b_q;
  logic [P_N-1:0]   sum_q;
  logic             carry_q;

  always_comb begin
    segSum = {1'b0, a_i[LO +: P_SEG]} + {1'b0, b_i[LO +: P_SEG]} + {{P_SEG{1'b0}}, carry_i};
    sum_d  = sum_i;
    sum_d[LO +: P_SEG] = segSum[P_SEG-1:0];
  end

  // Flush only kills the valid bit; payload is don't-care once invalid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      cmd_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      if (flush_i) begin
        valid_q <= 1'b0;
      end else if (!stall_i) begin
        valid_q <= valid_i;
      end
      if (!stall_i) begin
        cmd_q   <= cmd_i;
        a_q     <= a_i;
        b_q     <= b_i;
        sum_q   <= sum_d;
        carry_q <= segSum[P_SEG];
      end
    end
  end

  assign valid_o = valid_q;
  assign cmd_o   = cmd_q;
  assign a_o     = a_q;
  assign b_o     = b_q;
  assign sum_o   = sum_q;
  assign carry_o = carry_q;

endmodule

// File: rtl/execute_adder_pipe.sv
// Pipelined execute-stage adder: carry chain split into P_STAGES registered segments,
// with ADC/SBC, NEG, SEXT and subtract-compare MAX/MIN selection in the final stage.
module execute_adder_pipe #(
  parameter int P_N      = 32,
  parameter int P_STAGES = 2
) (
  input  logic           iCLOCK,
  input  logic           inRESET,
  input  logic           iRESET_SYNC,
  input  logic           iPREV_VALID,
  output logic           oPREV_BUSY,
  input  logic [4:0]     iADDER_CMD,
  input  logic [P_N-1:0] iDATA_0,
  input  logic [P_N-1:0] iDATA_1,
  input  logic           iCF,
  output logic           oNEXT_VALID,
  input  logic           iNEXT_BUSY,
  output logic [P_N-1:0] oDATA,
  output logic           oSF,
  output logic           oOF,
  output logic           oCF,
  output logic           oPF,
  output logic           oZF
);

  import execute_adder_pipe_pkg::*;

  localparam int P_SEG = P_N / P_STAGES;
  localparam int MSB   = P_N - 1;

  logic             stall;
  logic [P_N-1:0]   aPre;
  logic [P_N-1:0]   bPre;
  logic             cinPre;

  logic             validS [P_STAGES+1];
  logic [4:0]       cmdS   [P_STAGES+1];
  logic [P_N-1:0]   aS     [P_STAGES+1];
  logic [P_N-1:0]   bS     [P_STAGES+1];
  logic [P_N-1:0]   sumS   [P_STAGES+1];
  logic             carryS [P_STAGES+1];

  logic             lastValid;
  logic [4:0]       lastCmd;
  logic [P_N-1:0]   lastA;
  logic [P_N-1:0]   lastB;
  logic [P_N-1:0]   lastSum;
  logic             lastCo;
  logic             ofArith;
  logic             ltS;
  logic             ltU;
  logic [P_N-1:0]   origB;
  adderFlagsT       arithFlags;
  logic [P_N-1:0]   resultData;
  adderFlagsT       resultFlags;

  assign stall      = lastValid && iNEXT_BUSY;
  assign oPREV_BUSY = stall;

  always_comb begin
    aPre   = iDATA_0;
    bPre   = iDATA_1;
    cinPre = 1'b0;
    case (iADDER_CMD)
      EXE_ADDER_ADC: cinPre = iCF;
      EXE_ADDER_SBC: begin
        bPre   = ~iDATA_1;
        cinPre = iCF;
      end
      EXE_ADDER_NEG: begin
        aPre   = '0;
        bPre   = ~iDATA_0;
        cinPre = 1'b1;
      end
      // Sign extension rides the chain as 0 + B so it lands on the same cycle.
      EXE_ADDER_SEXT8, EXE_ADDER_SEXT16: aPre = '0;
      default: begin
        if (isSubtractCmd(iADDER_CMD)) begin
          bPre   = ~iDATA_1;
          cinPre = 1'b1;
        end
      end
    endcase
  end

  assign validS[0] = iPREV_VALID;
  assign cmdS[0]   = iADDER_CMD;
  assign aS[0]     = aPre;
  assign bS[0]     = bPre;
  assign sumS[0]   = '0;
  assign carryS[0] = cinPre;

  for (genvar k = 0; k < P_STAGES; k++) begin : gSeg
    execute_adder_pipe_seg #(
      .P_N   (P_N),
      .P_SEG (P_SEG),
      .P_IDX (k)
    ) uSeg (
      .clk_i   (iCLOCK),
      .rst_ni  (inRESET),
      .stall_i (stall),
      .flush_i (iRESET_SYNC),
      .valid_i (validS[k]),
      .cmd_i   (cmdS[k]),
      .a_i     (aS[k]),
      .b_i     (bS[k]),
      .sum_i   (sumS[k]),
      .carry_i (carryS[k]),
      .valid_o (validS[k+1]),
      .cmd_o   (cmdS[k+1]),
      .a_o     (aS[k+1]),
      .b_o     (bS[k+1]),
      .sum_o   (sumS[k+1]),
      .carry_o (carryS[k+1])
    );
  end

  assign lastValid = validS[P_STAGES];
  assign lastCmd   = cmdS[P_STAGES];
  assign lastA     = aS[P_STAGES];
  assign lastB     = bS[P_STAGES];
  assign lastSum   = sumS[P_STAGES];
  assign lastCo    = carryS[P_STAGES];

  // B' is already inverted for subtracts, so one overflow rule covers both directions.
  always_comb begin
    ofArith       = (lastA[MSB] == lastB[MSB]) && (lastSum[MSB] != lastA[MSB]);
    ltS           = lastSum[MSB] ^ ofArith;
    ltU           = !lastCo;
    origB         = ~lastB;
    arithFlags.sf = lastSum[MSB];
    arithFlags.of = ofArith;
    arithFlags.cf = lastCo;
    arithFlags.pf = lastSum[0];
    arithFlags.zf = (lastSum == '0);
    resultData    = '0;
    resultFlags   = '0;
    case (lastCmd)
      EXE_ADDER_ADD, EXE_ADDER_ADC, EXE_ADDER_SUB, EXE_ADDER_SBC: begin
        resultData  = lastSum;
        resultFlags = arithFlags;
      end
      EXE_ADDER_COUT: begin
        resultData  = {{(P_N-1){1'b0}}, lastCo};
        resultFlags = arithFlags;
      end
      EXE_ADDER_NEG:    resultData = lastSum;
      EXE_ADDER_SEXT8:  resultData = {{(P_N-8){lastSum[7]}}, lastSum[7:0]};
      EXE_ADDER_SEXT16: resultData = {{(P_N-16){lastSum[15]}}, lastSum[15:0]};
      EXE_ADDER_MAX:    resultData = ltS ? origB : lastA;
      EXE_ADDER_MIN:    resultData = ltS ? lastA : origB;
      EXE_ADDER_UMAX:   resultData = ltU ? origB : lastA;
      EXE_ADDER_UMIN:   resultData = ltU ? lastA : origB;
      default: ;
    endcase
    if (!lastValid) begin
      resultData  = '0;
      resultFlags = '0;
    end
  end

  assign oNEXT_VALID = lastValid;
  assign oDATA       = resultData;
  assign oSF         = resultFlags.sf;
  assign oOF         = resultFlags.of;
  assign oCF         = resultFlags.cf;
  assign oPF         = resultFlags.pf;
  assign oZF         = resultFlags.zf;

endmodule

// File: tb/tb_execute_adder_pipe.sv
// Bench for execute_adder_pipe: 2-stage and 4-stage instances checked against an
// arithmetic reference model, plus directed vectors with literal expectations.
module tb_execute_adder_pipe;

  import execute_adder_pipe_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  flags;
  } resT;

  logic        iCLOCK;
  logic        inRESET;
  logic        iRESET_SYNC;
  logic        iPREV_VALID;
  logic        iNEXT_BUSY;
  logic        iCF;
  logic [4:0]  iADDER_CMD;
  logic [31:0] iDATA_0;
  logic [31:0] iDATA_1;

  logic        oPREV_BUSY, oNEXT_VALID, oSF, oOF, oCF, oPF, oZF;
  logic [31:0] oDATA;
  logic [4:0]  flagsMain;

  logic        busy4, valid4, sf4, of4, cf4, pf4, zf4;
  logic [31:0] data4;
  logic [4:0]  flags4;
  logic        noBusy;

  int          total = 0;
  int          bad   = 0;
  resT         expQ[$];
  resT         expQ4[$];
  logic [31:0] outLog[$];

  assign flagsMain = {oSF, oOF, oCF, oPF, oZF};
  assign flags4    = {sf4, of4, cf4, pf4, zf4};
  assign noBusy    = 1'b0;

  execute_adder_pipe #(.P_N(32), .P_STAGES(2)) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC),
    .iPREV_VALID(iPREV_VALID), .oPREV_BUSY(oPREV_BUSY), .iADDER_CMD(iADDER_CMD),
    .iDATA_0(iDATA_0), .iDATA_1(iDATA_1), .iCF(iCF), .oNEXT_VALID(oNEXT_VALID),
    .iNEXT_BUSY(iNEXT_BUSY), .oDATA(oDATA), .oSF(oSF), .oOF(oOF), .oCF(oCF),
    .oPF(oPF), .oZF(oZF)
  );

  execute_adder_pipe #(.P_N(32), .P_STAGES(4)) dut4 (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC),
    .iPREV_VALID(iPREV_VALID), .oPREV_BUSY(busy4), .iADDER_CMD(iADDER_CMD),
    .iDATA_0(iDATA_0), .iDATA_1(iDATA_1), .iCF(iCF), .oNEXT_VALID(valid4),
    .iNEXT_BUSY(noBusy), .oDATA(data4), .oSF(sf4), .oOF(of4), .oCF(cf4),
    .oPF(pf4), .oZF(zf4)
  );

  initial iCLOCK = 1'b0;
  always #5 iCLOCK = ~iCLOCK;

  // Reference: plain 32-bit arithmetic; flags packed as {SF,OF,CF,PF,ZF}.
  function automatic resT model(input logic [4:0] cmd, input logic [31:0] a,
                                input logic [31:0] b, input logic cf);
    resT         r;
    logic [32:0] w;
    logic [31:0] d;
    logic        c, o;
    r = '0;
    d = '0; c = 1'b0; o = 1'b0;
    case (cmd)
      EXE_ADDER_ADD, EXE_ADDER_ADC, EXE_ADDER_COUT: begin
        w = {1'b0, a} + {1'b0, b} + ((cmd == EXE_ADDER_ADC) ? {32'd0, cf} : 33'd0);
        d = w[31:0];
        c = w[32];
        o = (a[31] == b[31]) && (d[31] != a[31]);
      end
      EXE_ADDER_SUB, EXE_ADDER_SBC: begin
        w = {1'b0, b} + ((cmd == EXE_ADDER_SBC) ? {32'd0, !cf} : 33'd0);
        d = a - w[31:0];
        c = ({1'b0, a} >= w);
        o = (a[31] != b[31]) && (d[31] != a[31]);
      end
      default: ;
    endcase
    case (cmd)
      EXE_ADDER_ADD, EXE_ADDER_ADC, EXE_ADDER_SUB, EXE_ADDER_SBC:
        r = '{data: d, flags: {d[31], o, c, d[0], (d == 32'd0)}};
      EXE_ADDER_COUT:
        r = '{data: {31'd0, c}, flags: {d[31], o, c, d[0], (d == 32'd0)}};
      EXE_ADDER_NEG:    r.data = -a;
      EXE_ADDER_SEXT8:  r.data = {{24{b[7]}}, b[7:0]};
      EXE_ADDER_SEXT16: r.data = {{16{b[15]}}, b[15:0]};
      EXE_ADDER_MAX:    r.data = ($signed(a) < $signed(b)) ? b : a;
      EXE_ADDER_MIN:    r.data = ($signed(a) < $signed(b)) ? a : b;
      EXE_ADDER_UMAX:   r.data = (a < b) ? b : a;
      EXE_ADDER_UMIN:   r.data = (a < b) ? a : b;
      default: ;
    endcase
    return r;
  endfunction

  always @(negedge iCLOCK) begin
    resT got;
    got = {oDATA, flagsMain};
    if (!inRESET) begin
      total++;
      if (oNEXT_VALID !== 1'b0 || got !== '0) begin
        bad++;
        $display("[TB] FAIL main_in_reset: got valid=%b data=%h flags=%b, want all 0", oNEXT_VALID, oDATA, flagsMain);
      end
      expQ.delete();
    end else begin
      if (oNEXT_VALID) begin
        total++;
        if (expQ.size() == 0) begin
          bad++;
          $display("[TB] FAIL main_spurious: got data=%h flags=%b, want no valid output", oDATA, flagsMain);
        end else begin
          if (got !== expQ[0]) begin
            bad++;
            $display("[TB] FAIL main_result: got data=%h flags=%b, want data=%h flags=%b", oDATA, flagsMain, expQ[0].data, expQ[0].flags);
          end
          if (!iNEXT_BUSY) begin
            void'(expQ.pop_front());
            outLog.push_back(oDATA);
          end
        end
      end
      if (iRESET_SYNC) expQ.delete();
      else if (iPREV_VALID && !oPREV_BUSY) expQ.push_back(model(iADDER_CMD, iDATA_0, iDATA_1, iCF));
    end
  end

  always @(negedge iCLOCK) begin
    resT got;
    got = {data4, flags4};
    if (!inRESET) begin
      expQ4.delete();
    end else begin
      if (valid4) begin
        total++;
        if (expQ4.size() == 0) begin
          bad++;
          $display("[TB] FAIL s4_spurious: got data=%h flags=%b, want no valid output", data4, flags4);
        end else begin
          if (got !== expQ4[0]) begin
            bad++;
            $display("[TB] FAIL s4_result: got data=%h flags=%b, want data=%h flags=%b", data4, flags4, expQ4[0].data, expQ4[0].flags);
          end
          void'(expQ4.pop_front());
        end
      end
      if (iRESET_SYNC) expQ4.delete();
      else if (iPREV_VALID && !busy4) expQ4.push_back(model(iADDER_CMD, iDATA_0, iDATA_1, iCF));
    end
  end

  // Presents one op and returns #1 after the edge that accepts it.
  task automatic applyStimulus(input logic [4:0] cmd, input logic [31:0] a,
                               input logic [31:0] b, input logic cf);
    int n = 0;
    iADDER_CMD  = cmd;
    iDATA_0     = a;
    iDATA_1     = b;
    iCF         = cf;
    iPREV_VALID = 1'b1;
    @(negedge iCLOCK);
    while (oPREV_BUSY && n < 50) begin
      @(negedge iCLOCK);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: got busy for %0d cycles, want acceptance", n);
    end
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] expData, input logic [4:0] expFlags);
    int lat = 1;
    @(negedge iCLOCK);
    while (!oNEXT_VALID && lat < 20) begin
      @(posedge iCLOCK);
      lat++;
      @(negedge iCLOCK);
    end
    total++;
    if (!oNEXT_VALID || lat != 2 || oDATA !== expData || flagsMain !== expFlags) begin
      bad++;
      $display("[TB] FAIL %s: got valid=%b lat=%0d data=%h flags=%b, want valid=1 lat=2 data=%h flags=%b",
               name, oNEXT_VALID, lat, oDATA, flagsMain, expData, expFlags);
    end
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic runDirected(input string name, input logic [4:0] cmd, input logic [31:0] a,
                             input logic [31:0] b, input logic cf,
                             input logic [31:0] expData, input logic [4:0] expFlags);
    applyStimulus(cmd, a, b, cf);
    iPREV_VALID = 1'b0;
    checkOutput(name, expData, expFlags);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h0000_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic [4:0]  cmdTable [14];
    logic [31:0] l0, l1, l2;
    int          seen;
    cmdTable = '{EXE_ADDER_ADD, EXE_ADDER_SUB, EXE_ADDER_NEG, EXE_ADDER_COUT, EXE_ADDER_SEXT8,
                 EXE_ADDER_SEXT16, EXE_ADDER_MAX, EXE_ADDER_MIN, EXE_ADDER_UMAX, EXE_ADDER_UMIN,
                 EXE_ADDER_ADC, EXE_ADDER_SBC, 5'h0C, 5'h1F};
    inRESET = 1'b0; iRESET_SYNC = 1'b0; iPREV_VALID = 1'b0; iNEXT_BUSY = 1'b0;
    iCF = 1'b0; iADDER_CMD = '0; iDATA_0 = '0; iDATA_1 = '0;
    #2;
    total++;
    if ({oNEXT_VALID, oPREV_BUSY, oDATA, flagsMain, valid4, data4} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_state: got valid=%b busy=%b data=%h flags=%b, want all 0", oNEXT_VALID, oPREV_BUSY, oDATA, flagsMain);
    end
    repeat (2) @(posedge iCLOCK);
    #1 inRESET = 1'b1;

    runDirected("add_wrap",   EXE_ADDER_ADD,  32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0,         5'b00101);
    runDirected("add_ovf",    EXE_ADDER_ADD,  32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 5'b11000);
    runDirected("sub_neg",    EXE_ADDER_SUB,  32'd5,  32'd7, 1'b0, 32'hFFFF_FFFE, 5'b10000);
    runDirected("sbc_borrow", EXE_ADDER_SBC,  32'd10, 32'd3, 1'b0, 32'd6,         5'b00100);
    runDirected("adc_cross",  EXE_ADDER_ADC,  32'h0000_FFFF, 32'h1, 1'b1, 32'h0001_0001, 5'b00010);
    runDirected("max_s",      EXE_ADDER_MAX,  32'hFFFF_FFFF, 32'h1, 1'b0, 32'h1,         5'b00000);
    runDirected("min_s",      EXE_ADDER_MIN,  32'hFFFF_FFFF, 32'h1, 1'b0, 32'hFFFF_FFFF, 5'b00000);
    runDirected("umax",       EXE_ADDER_UMAX, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'hFFFF_FFFF, 5'b00000);
    runDirected("umin",       EXE_ADDER_UMIN, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h1,         5'b00000);
    runDirected("max_ovf",    EXE_ADDER_MAX,  32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32'h7FFF_FFFF, 5'b00000);
    runDirected("max_equal",  EXE_ADDER_MAX,  32'd5, 32'd5, 1'b0, 32'd5, 5'b00000);
    runDirected("cout",       EXE_ADDER_COUT, 32'hFFFF_FFFF, 32'h2, 1'b0, 32'h1, 5'b00110);
    runDirected("neg",        EXE_ADDER_NEG,  32'h1, 32'h0, 1'b0, 32'hFFFF_FFFF, 5'b00000);
    runDirected("sext16",     EXE_ADDER_SEXT16, 32'h0, 32'hABCD_1234, 1'b0, 32'h0000_1234, 5'b00000);
    runDirected("undef_cmd",  5'h1F, 32'h1234, 32'h5678, 1'b1, 32'h0, 5'b00000);

    // Back-to-back ops with the consumer stalling three cycles on the first result.
    outLog.delete();
    applyStimulus(EXE_ADDER_ADD, 32'h100, 32'h23, 1'b0);
    applyStimulus(EXE_ADDER_SEXT8, 32'h0, 32'h80, 1'b0);
    iADDER_CMD = EXE_ADDER_NEG; iDATA_0 = 32'h1; iDATA_1 = 32'h0; iNEXT_BUSY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge iCLOCK);
      total++;
      if ({oPREV_BUSY, oNEXT_VALID, oDATA} !== {1'b1, 1'b1, 32'h123}) begin
        bad++;
        $display("[TB] FAIL stall_hold: got busy=%b valid=%b data=%h, want busy=1 valid=1 data=00000123", oPREV_BUSY, oNEXT_VALID, oDATA);
      end
      @(posedge iCLOCK);
      #1;
    end
    iNEXT_BUSY = 1'b0;
    @(negedge iCLOCK);
    @(posedge iCLOCK);
    #1 iPREV_VALID = 1'b0;
    repeat (6) @(posedge iCLOCK);
    #1;
    l0 = 'x; l1 = 'x; l2 = 'x;
    if (outLog.size() > 0) l0 = outLog[0];
    if (outLog.size() > 1) l1 = outLog[1];
    if (outLog.size() > 2) l2 = outLog[2];
    total++;
    if (outLog.size() != 3 || l0 !== 32'h123 || l1 !== 32'hFFFF_FF80 || l2 !== 32'hFFFF_FFFF) begin
      bad++;
      $display("[TB] FAIL stall_order: got n=%0d %h %h %h, want n=3 00000123 ffffff80 ffffffff", outLog.size(), l0, l1, l2);
    end

    // Flush while an op is in flight and another is being presented.
    applyStimulus(EXE_ADDER_ADD, 32'h1, 32'h1, 1'b0);
    iDATA_0 = 32'h2; iDATA_1 = 32'h2; iRESET_SYNC = 1'b1;
    @(posedge iCLOCK);
    #1 iRESET_SYNC = 1'b0; iPREV_VALID = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge iCLOCK);
      if (oNEXT_VALID) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("[TB] FAIL flush_drop: got %0d valid cycles, want 0", seen);
    end
    @(posedge iCLOCK);
    #1;
    runDirected("after_flush", EXE_ADDER_ADD, 32'd3, 32'd4, 1'b0, 32'd7, 5'b00010);

    // Flush while the output is stalled: flush wins.
    applyStimulus(EXE_ADDER_ADD, 32'd9, 32'd9, 1'b0);
    iPREV_VALID = 1'b0;
    @(posedge iCLOCK);
    #1 iNEXT_BUSY = 1'b1; iRESET_SYNC = 1'b1;
    @(posedge iCLOCK);
    #1 iRESET_SYNC = 1'b0;
    @(negedge iCLOCK);
    total++;
    if ({oNEXT_VALID, oPREV_BUSY} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL flush_over_stall: got valid=%b busy=%b, want 0 0", oNEXT_VALID, oPREV_BUSY);
    end
    @(posedge iCLOCK);
    #1 iNEXT_BUSY = 1'b0;

    // Asynchronous reset while a result is on the output.
    applyStimulus(EXE_ADDER_ADD, 32'h10, 32'h20, 1'b0);
    iPREV_VALID = 1'b0;
    @(posedge iCLOCK);
    #2 inRESET = 1'b0;
    #1;
    total++;
    if ({oNEXT_VALID, oDATA, flagsMain, valid4, data4} !== '0) begin
      bad++;
      $display("[TB] FAIL async_reset: got valid=%b data=%h flags=%b valid4=%b, want all 0", oNEXT_VALID, oDATA, flagsMain, valid4);
    end
    repeat (2) @(posedge iCLOCK);
    #3 inRESET = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge iCLOCK);
      if (oNEXT_VALID || valid4) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("[TB] FAIL reset_loses_op: got %0d valid cycles, want 0", seen);
    end
    @(posedge iCLOCK);
    #1;

    // Mixed random traffic with stalls and occasional flushes.
    for (int i = 0; i < 400; i++) begin
      iPREV_VALID = ($urandom_range(0, 3) != 0);
      iADDER_CMD  = cmdTable[$urandom_range(0, 13)];
      iDATA_0     = pickOperand();
      iDATA_1     = pickOperand();
      iCF         = 1'($urandom_range(0, 1));
      iNEXT_BUSY  = ($urandom_range(0, 3) == 0);
      iRESET_SYNC = ($urandom_range(0, 49) == 0);
      @(posedge iCLOCK);
      #1;
    end
    iPREV_VALID = 1'b0; iNEXT_BUSY = 1'b0; iRESET_SYNC = 1'b0;
    repeat (20) @(posedge iCLOCK);
    #1;
    total++;
    if (expQ.size() != 0 || expQ4.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d and %0d results outstanding, want 0 and 0", expQ.size(), expQ4.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
